udp_mch_packetizer: RTL and testbench



---
 rtl/udp_mch_packetizer.sv | 121 ++++++++++++
 tb/tb_udp_mch_packetizer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/udp_mch_packetizer.sv
// udp_mch_packetizer: round-robin multi-channel byte packetizer with an 8-byte application header
module udp_mch_packetizer #(
    parameter int         N_CH    = 2,
    parameter int         PAYLOAD = 1024,
    parameter int         IFG     = 12,
    parameter logic [7:0] MAGIC   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [N_CH-1:0]   ch_avail,
    input  logic [N_CH-1:0]   ch_valid,
    input  logic [8*N_CH-1:0] ch_data,
    input  logic [N_CH-1:0]   ch_sof,
    output logic [N_CH-1:0]   ch_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy
);
    localparam int SW = N_CH > 1 ? $clog2(N_CH) : 1;
    typedef enum logic [1:0] {IDLE, HDR, PAY, GAP} state_t;
    state_t        r_state, w_next;
    logic [SW-1:0] r_sel, r_rr, w_pick, w_j;
    logic          r_sof0;
    logic [2:0]    r_idx;
    logic [15:0]   r_cnt;
    logic [7:0]    r_gap;
    logic [15:0]   r_frame_cnt [N_CH];
    logic [15:0]   r_pkt_cnt [N_CH];
    logic [15:0]   w_frame_no, w_pkt_no;
    logic [7:0]    w_bytes [N_CH];
    logic [7:0]    w_hdr [8];
    logic          w_start, w_xfer, w_last;
    assign w_start    = enable & (|ch_avail);
    assign w_xfer     = out_valid & out_ready;
    assign w_last     = r_cnt == 16'(PAYLOAD - 1);
    assign w_frame_no = r_frame_cnt[r_sel] + 16'(r_sof0);
    assign w_pkt_no   = r_sof0 ? 16'd0 : r_pkt_cnt[r_sel];
    assign w_hdr[0]   = MAGIC;
    assign w_hdr[1]   = {3'b000, r_sof0, 4'(r_sel)};
    assign w_hdr[2]   = w_frame_no[15:8];
    assign w_hdr[3]   = w_frame_no[7:0];
    assign w_hdr[4]   = w_pkt_no[15:8];
    assign w_hdr[5]   = w_pkt_no[7:0];
    assign w_hdr[6]   = 8'(PAYLOAD >> 8);
    assign w_hdr[7]   = 8'(PAYLOAD);
    // split the flat channel data bus into per-channel bytes
    always_comb begin
        for (int i = 0; i < N_CH; i++) w_bytes[i] = ch_data[8*i +: 8];
    end
    // round-robin pick: nearest requesting channel above the last served one wins
    always_comb begin
        w_pick = r_rr;
        w_j    = '0;
        for (int k = N_CH; k >= 1; k--) begin
            w_j = SW'((int'(r_rr) + k) % N_CH);
            if (ch_avail[w_j]) w_pick = w_j;
        end
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_start ? HDR : IDLE;
            HDR:     w_next = (w_xfer && r_idx == 3'd7) ? PAY : HDR;
            PAY:     w_next = (w_xfer && w_last) ? ((IFG == 0) ? IDLE : GAP) : PAY;
            default: w_next = (r_gap == 8'(IFG - 1)) ? IDLE : GAP;
        endcase
    end
    // outputs: header bytes from the index, payload passed straight through from the selected channel
    always_comb begin
        ch_ready         = '0;
        ch_ready[r_sel]  = (r_state == PAY) & out_ready;
        out_valid        = (r_state == HDR) | ((r_state == PAY) & ch_valid[r_sel]);
        out_data         = (r_state == HDR) ? w_hdr[r_idx] : (r_state == PAY) ? w_bytes[r_sel] : 8'h00;
        out_sop          = (r_state == HDR) & (r_idx == 3'd0);
        out_eop          = (r_state == PAY) & ch_valid[r_sel] & w_last;
        busy             = r_state != IDLE;
    end
    // datapath: selection, byte counters and per-channel frame/packet numbering
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel  <= '0;
            r_rr   <= SW'(N_CH - 1);
            r_sof0 <= 1'b0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_gap  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_frame_cnt[i] <= '0;
                r_pkt_cnt[i]   <= '0;
            end
        end else begin
            if (r_state == IDLE && w_start) begin
                r_sel  <= w_pick;
                r_sof0 <= ch_sof[w_pick] & ch_valid[w_pick];
                r_idx  <= '0;
                r_cnt  <= '0;
            end
            if (r_state == HDR && w_xfer) r_idx <= r_idx + 3'd1;
            if (r_state == PAY && w_xfer) begin
                r_cnt <= r_cnt + 16'd1;
                if (ch_sof[r_sel]) r_frame_cnt[r_sel] <= r_frame_cnt[r_sel] + 16'd1;
                if (w_last) begin
                    r_pkt_cnt[r_sel] <= w_pkt_no + 16'd1;
                    r_rr             <= r_sel;
                    r_gap            <= '0;
                end
            end
            if (r_state == GAP) r_gap <= r_gap + 8'd1;
        end
    end
endmodule

// File: tb/tb_udp_mch_packetizer.sv
// tb_udp_mch_packetizer: directed scoreboard bench for the multi-channel packetizer
module tb_udp_mch_packetizer;
    localparam int N = 2;
    localparam int P = 8;
    localparam int G = 2;
    logic         clk = 0, rst = 1, enable = 0, out_ready = 0;
    logic [N-1:0] ch_avail = '0, ch_valid = '0, ch_sof = '0, ch_ready;
    logic [8*N-1:0] ch_data = '0;
    logic         out_valid, out_sop, out_eop, busy;
    logic [7:0]   out_data;
    int           total = 0, bad = 0;
    logic [8:0]   q0[$], q1[$];
    logic [9:0]   expq[$];
    logic [N-1:0] hold = '0, pop_now;
    bit           tog = 0, rdy_base = 0;
    int           pops0 = 0, pay_idx = 0, gap_n = 0;
    int           m_frame[N], m_pkt[N];
    logic         prev_stall = 0;
    logic [9:0]   prev_word = '0, e;

    always #5 clk = ~clk;

    udp_mch_packetizer #(.N_CH(N), .PAYLOAD(P), .IFG(G), .MAGIC(8'hA5)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_avail(ch_avail), .ch_valid(ch_valid),
        .ch_data(ch_data), .ch_sof(ch_sof), .ch_ready(ch_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .busy(busy)
    );

    task automatic check(string tag, logic [31:0] o, logic [31:0] x);
        total++;
        assert (o === x) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
        end
    endtask

    task automatic refresh();
        ch_valid[0]  = q0.size() > 0 && !hold[0];
        ch_sof[0]    = q0.size() > 0 && q0[0][8];
        ch_data[7:0] = q0.size() > 0 ? q0[0][7:0] : 8'h00;
        ch_avail[0]  = q0.size() >= P;
        ch_valid[1]  = q1.size() > 0 && !hold[1];
        ch_sof[1]    = q1.size() > 0 && q1[0][8];
        ch_data[15:8] = q1.size() > 0 ? q1[0][7:0] : 8'h00;
        ch_avail[1]  = q1.size() >= P;
    endtask

    // queue one packet of payload on a channel; if expected, push header+payload to the scoreboard
    task automatic pkt(int ch, logic [7:0] base, int sof_at, bit expect_it);
        logic        sof0;
        logic [15:0] fn, pn;
        logic [7:0]  hdr [8];
        sof0 = sof_at == 0;
        for (int i = 0; i < P; i++) begin
            if (ch == 0) q0.push_back({1'(sof_at == i), 8'(base + i)});
            else         q1.push_back({1'(sof_at == i), 8'(base + i)});
        end
        if (expect_it) begin
            fn = 16'(m_frame[ch] + int'(sof0));
            pn = sof0 ? 16'd0 : 16'(m_pkt[ch]);
            hdr[0] = 8'hA5; hdr[1] = {3'b000, sof0, 4'(ch)};
            hdr[2] = fn[15:8]; hdr[3] = fn[7:0]; hdr[4] = pn[15:8]; hdr[5] = pn[7:0];
            hdr[6] = 8'(P >> 8); hdr[7] = 8'(P);
            for (int i = 0; i < 8; i++) expq.push_back({1'(i == 0), 1'b0, hdr[i]});
            for (int i = 0; i < P; i++) expq.push_back({1'b0, 1'(i == P - 1), 8'(base + i)});
            if (sof_at >= 0) m_frame[ch] = m_frame[ch] + 1;
            m_pkt[ch] = int'(pn) + 1;
        end
    endtask

    task automatic wait_drain(string tag, int budget);
        int n = 0;
        while (expq.size() != 0 && n < budget) begin @(negedge clk); n++; end
        check({tag, "_drain"}, expq.size(), 0);
    endtask

    task automatic wait_idx(string tag, int k, int budget);
        int n = 0;
        while (pay_idx != k && n < budget) begin @(negedge clk); n++; end
        check({tag, "_reach"}, pay_idx, k);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin m_frame[i] = 0; m_pkt[i] = 0; end
    endtask

    // channel FIFO model and out_ready pattern, updated just after each edge
    always @(posedge clk) begin
        pop_now = ch_ready & ch_valid;
        #1;
        if (pop_now[0]) begin void'(q0.pop_front()); pops0++; end
        if (pop_now[1]) void'(q1.pop_front());
        out_ready = tog ? ~out_ready : rdy_base;
        refresh();
    end

    // monitor: scoreboard compare, stall stability and inter-packet gap
    always @(negedge clk) begin
        if (!rst) begin
            if (gap_n > 0) begin
                check("gap_valid", 32'(out_valid), 0);
                check("gap_busy", 32'(busy), 32'(gap_n > 1));
                gap_n--;
            end
            if (prev_stall && out_valid) check("stall_stable", {out_sop, out_eop, out_data}, prev_word);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    total++; bad++;
                    $error("FAIL unexpected_byte observed=%0h expected=none", {out_sop, out_eop, out_data});
                end else begin
                    e = expq.pop_front();
                    check("byte", {out_sop, out_eop, out_data}, e);
                end
                pay_idx = out_sop ? 1 : pay_idx + 1;
                if (out_eop) gap_n = G + 1;
            end
        end
        prev_stall = !rst && out_valid && !out_ready;
        prev_word  = {out_sop, out_eop, out_data};
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_ready", 32'(ch_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_data", 32'({out_sop, out_eop, out_data}), 0);
        rst = 0; rdy_base = 1; enable = 1;
        // single packet on ch0 with frame start on the first byte
        pkt(0, 8'h10, 0, 1);
        wait_drain("t1", 100);
        repeat (5) @(negedge clk);
        rst = 1; @(negedge clk); rst = 0; model_reset();
        // both channels requesting: strict alternation starting at ch0
        pkt(0, 8'h20, 0, 1); pkt(1, 8'h30, 0, 1); pkt(0, 8'h28, -1, 1); pkt(1, 8'h38, -1, 1);
        wait_drain("t2", 400);
        // backpressure toggling plus a 5-cycle source gap mid-payload
        repeat (4) @(negedge clk);
        pops0 = 0; tog = 1;
        pkt(0, 8'h10, 0, 1);
        wait_idx("t3", 11, 200);
        hold[0] = 1;
        repeat (5) @(negedge clk);
        hold[0] = 0;
        wait_drain("t3", 200);
        tog = 0;
        repeat (3) @(negedge clk);
        check("t3_pops", pops0, 8);
        // frame start inside the payload only bumps the next packet's frame number
        pkt(0, 8'h40, 3, 1); pkt(0, 8'h48, -1, 1);
        wait_drain("t4", 200);
        // asynchronous reset mid-payload
        pkt(0, 8'h50, 0, 1);
        wait_idx("t5", 12, 200);
        #2 rst = 1;
        #1;
        check("t5_valid", 32'(out_valid), 0);
        check("t5_ready", 32'(ch_ready), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_data", 32'(out_data), 0);
        q0.delete(); q1.delete(); expq.delete(); model_reset(); pay_idx = 0;
        @(negedge clk); rst = 0;
        pkt(0, 8'h70, 0, 1); pkt(1, 8'h60, 0, 1);
        wait_drain("t5", 300);
        repeat (5) @(negedge clk);
        // enable low holds off new packets; dropping it mid-packet lets the packet finish
        enable = 0;
        pkt(0, 8'h80, 0, 1); pkt(0, 8'h88, -1, 0);
        repeat (8) begin
            @(negedge clk);
            check("t6_idle_valid", 32'(out_valid), 0);
            check("t6_idle_busy", 32'(busy), 0);
        end
        enable = 1;
        wait_idx("t6", 10, 100);
        enable = 0;
        wait_drain("t6", 100);
        repeat (20) begin
            @(negedge clk);
            check("t6_no_sop", 32'({out_valid, out_sop}), 0);
        end
        check("t6_busy_end", 32'(busy), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
